// File: rtl/arb2x1_stream.sv
`default_nettype none
// ============================================================================
// Module   : arb2x1_stream
// Purpose  : Two-input round-robin valid/ready arbiter with a registered
//            single-entry output stage and a registered mux-select tag.
//            Optional feature macro: ARB2X1_BURST_EN (bounded burst grants).
// Revision : 1.0 - initial release
// ============================================================================
module arb2x1_stream #(
  parameter int WIDTH     = 8,
  parameter int BURST_LEN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_valid,
  output logic             b_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sel
);

  generate
    if (BURST_LEN < 1 || BURST_LEN > 255) begin : g_burst_len_check
      $error("arb2x1_stream: BURST_LEN must be within 1..255");
    end
  endgenerate

  logic last_a;   // 1: most recent transfer came from A
  logic grant_a;
  logic grant_b;
  logic load;

`ifdef ARB2X1_BURST_EN
  localparam logic [7:0] BURST_MAX = 8'(BURST_LEN);
  logic [7:0] burst_cnt;
  logic       keep_owner;

  // A zero count means no owner yet, so the first tie goes to the non-last side.
  assign keep_owner = (burst_cnt != 8'd0) && (burst_cnt < BURST_MAX);
`endif

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (a_valid && b_valid) begin
`ifdef ARB2X1_BURST_EN
      grant_a = keep_owner ? last_a : !last_a;
`else
      grant_a = !last_a;
`endif
      grant_b = !grant_a;
    end else begin
      grant_a = a_valid;
      grant_b = b_valid;
    end
  end

  assign load = !out_valid || out_ready;

  // Gating with rst_n keeps any handshake from completing while reset is held.
  assign a_ready = rst_n && load && grant_a;
  assign b_ready = rst_n && load && grant_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      sel       <= 1'b0;
      last_a    <= 1'b0;
    end else if (load) begin
      if (grant_a || grant_b) begin
        out_valid <= 1'b1;
        out_data  <= grant_a ? a_data : b_data;
        sel       <= grant_a;
        last_a    <= grant_a;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef ARB2X1_BURST_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt <= 8'd0;
    end else if (load && (grant_a || grant_b)) begin
      if (grant_a == last_a) begin
        burst_cnt <= (burst_cnt >= BURST_MAX) ? BURST_MAX : burst_cnt + 8'd1;
      end else begin
        burst_cnt <= 8'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/arb2x1_stream.md
# arb2x1_stream

Two-input round-robin stream arbiter with a registered single-entry output stage. It sits directly upstream of the 2:1 mux datapath: it decides which of two valid/ready producers (A, B) is forwarded, and drives both the merged stream and a registered `sel` that follows the mux convention (`out = sel ? a : b`). It is the control stage that turns the combinational mux into a flow-controlled merge point.

## Interface
- `WIDTH`, 8, data width of every channel
- `BURST_LEN`, 4, maximum consecutive grants to one source under contention (used only with `ARB2X1_BURST_EN`; legal range 1..255)

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `a_data`  in  WIDTH  source A payload
- `a_valid`  in  1  source A offers `a_data`
- `a_ready`  out  1  A word accepted this cycle when `a_valid & a_ready`
- `b_data`  in  WIDTH  source B payload
- `b_valid`  in  1  source B offers `b_data`
- `b_ready`  out  1  B word accepted this cycle when `b_valid & b_ready`
- `out_data`  out  WIDTH  registered merged payload
- `out_valid`  out  1  `out_data` holds a word
- `out_ready`  in  1  downstream consumes when `out_valid & out_ready`
- `sel`  out  1  registered source tag of the word in `out_data`: 1 = A, 0 = B

## Operation
- Output stage: one register (`out_data`, `out_valid`, `sel`). `load = !out_valid | out_ready`.
- Grant (combinational, from valids and `last`): only A valid → A; only B valid → B; both valid → source ≠ `last`; none → no grant.
- `a_ready = load & grant_A`; `b_ready = load & grant_B`. At most one ready high per cycle; ready never asserted to an idle source.
- On a load with a grant: `out_data` ← granted data, `sel` ← (grant == A), `out_valid` ← 1, `last` ← granted source.
- On a load without a grant: `out_valid` ← 0; `out_data` and `sel` hold.
- When `out_valid & !out_ready`: register holds, both readies low (backpressure).
- `last` is updated only on an actual transfer; a source dropping valid does not move it.
- Throughput one word per cycle under continuous `out_ready`; no bubbles on grant switch.

## Timing
- Reset values: `out_valid` 0, `out_data` 0, `sel` 0, `a_ready` 0, `b_ready` 0 (readies are combinational but forced by `out_valid`=0 and valids; with inputs idle they are 0), `last` = B (so A wins first tie), burst counter 0.
- Latency: input handshake in cycle N → word on `out_data`/`out_valid` after edge N+1.
- `a_ready`/`b_ready` depend combinationally on `out_ready`, `a_valid`, `b_valid`; no combinational path from any data input to any output.
- Asynchronous reset mid-transfer: in-flight word dropped, `out_valid` falls immediately without waiting for `clk`; no handshake completes on the edge where `rst_n` is low.
- Simultaneous pop and push: downstream consumes old word and new word loads on the same edge.

## Configuration
- `ARB2X1_BURST_EN` defined: an 8-bit counter `burst_cnt` counts consecutive transfers from `last`. Under contention the owner `last` keeps the grant while `burst_cnt < BURST_LEN`; at `BURST_LEN` the other source is granted and `burst_cnt` restarts at 1. Uncontended transfers from `last` increment the counter (saturating at `BURST_LEN`); a transfer from the other source sets it to 1.
- Not defined: strict alternation under contention (equivalent to `BURST_LEN` = 1); no counter present; `BURST_LEN` ignored.

## Test plan
- Reset: drive `rst_n`=0 with `a_valid`=`b_valid`=1 → `out_valid`=0, `out_data`=0x00, `sel`=0, no ready sampled high on any edge.
- Single source: A sends 0x11, 0x22, 0x33 back-to-back, `out_ready`=1, B idle → `out_data` 0x11,0x22,0x33 on consecutive cycles, `sel`=1 each, one-cycle latency.
- Contention, macro off: A holds 0xA0.., B holds 0xB0.., `out_ready`=1 → output order A,B,A,B…, `sel` 1,0,1,0, first winner A after reset.
- Contention, `ARB2X1_BURST_EN`, `BURST_LEN`=4 → order AAAA BBBB AAAA, `sel` matching.
- Backpressure: both valid, `out_ready`=0 for 3 cycles after first load → `out_data` frozen, `a_ready`=`b_ready`=0, no word lost or duplicated once `out_ready` returns.
- Reset mid-stream: assert `rst_n`=0 between edges while `out_valid`=1 → `out_valid` 0 immediately; after release, first contended grant goes to A.
